// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// Inputs above MAX_VALUE are saturated and flagged via overflow.
module bin_to_bcd_seq #(
    parameter int unsigned N_BITS    = 16,
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned MAX_VALUE = 9999
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N_BITS-1:0]     bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] bcd_out,
    output logic                  overflow
);

    localparam int unsigned BcdW = 4 * N_DIGITS;
    localparam int unsigned SrW  = BcdW + N_BITS;
    localparam int unsigned CntW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [N_BITS-1:0] MaxVal  = N_BITS'(MAX_VALUE);
    localparam logic [CntW-1:0]   LastCnt = CntW'(N_BITS - 1);

    typedef enum logic [1:0] {StIdle, StConvert, StFinish} state_e;

    state_e           state_q, state_d;
    logic [SrW-1:0]   sr_q, sr_adj;
    logic [CntW-1:0]  cnt_q;
    logic             ovf_q;
    logic             done_q;
    logic [BcdW-1:0]  bcd_q;
    logic             overflow_q;
    logic             sat;
    logic [N_BITS-1:0] bin_sat;

    assign sat     = (bin_in > MaxVal);
    assign bin_sat = sat ? MaxVal : bin_in;

    // Add-3 on every BCD nibble >= 5, no carry between nibbles.
    always_comb begin
        sr_adj = sr_q;
        for (int d = 0; d < int'(N_DIGITS); d++) begin
            if (sr_q[N_BITS+4*d +: 4] >= 4'd5) begin
                sr_adj[N_BITS+4*d +: 4] = sr_q[N_BITS+4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StConvert;
            StConvert: if (cnt_q == LastCnt) state_d = StFinish;
            StFinish:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        sr_q  <= {{BcdW{1'b0}}, bin_sat};
                        ovf_q <= sat;
                        cnt_q <= '0;
                    end
                end
                StConvert: begin
                    sr_q  <= {sr_adj[SrW-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                end
                StFinish: begin
                    bcd_q      <= sr_q[SrW-1 -: BcdW];
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = overflow_q;

endmodule
